// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: button edge detection, run/pause/lap FSM,
// tenths-tick prescaler and free-running display-scan prescaler.
// All outputs are registered; button edges act at the edge that sees them.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       tick_en,
  output logic       clr,
  output logic       freeze,
  output logic       scan_en,
  output logic       running,
  output logic [1:0] state
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic          start_prev_reg, lap_prev_reg;
  logic          start_edge, lap_edge;
  logic          running_reg, running_next;
  logic          freeze_reg, freeze_next;
  logic          clr_reg, clr_next;
  logic          tick_en_reg, scan_en_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] scan_cnt_reg;

  // Previous-level registers reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_reg <= 1'b1;
      lap_prev_reg   <= 1'b1;
    end else begin
      start_prev_reg <= btn_start;
      lap_prev_reg   <= btn_lap;
    end
  end

  assign start_edge = btn_start & ~start_prev_reg;
  assign lap_edge   = btn_lap & ~lap_prev_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a start edge takes priority and swallows a simultaneous lap edge.
  always_comb begin
    state_next = state_reg;
    if (start_edge) begin
      unique case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        LAP:     state_next = PAUSE;
        default: state_next = IDLE;
      endcase
    end else if (lap_edge) begin
      unique case (state_reg)
        IDLE:    state_next = IDLE;
        RUN:     state_next = LAP;
        PAUSE:   state_next = IDLE;
        LAP:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so flags change together with the state.
  always_comb begin
    running_next = (state_next == RUN) || (state_next == LAP);
    freeze_next  = (state_next == LAP);
    clr_next     = lap_edge && !start_edge &&
                   ((state_reg == IDLE) || (state_reg == PAUSE));
  end

  // Registered FSM outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_reg <= 1'b0;
      freeze_reg  <= 1'b0;
      clr_reg     <= 1'b0;
    end else begin
      running_reg <= running_next;
      freeze_reg  <= freeze_next;
      clr_reg     <= clr_next;
    end
  end

  // Tick prescaler: advances only while running, holds in PAUSE, zeroed on entry to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_reg <= '0;
      tick_en_reg  <= 1'b0;
    end else begin
      tick_en_reg <= running_reg && (tick_cnt_reg == TICK_MAX);
      if (state_next == IDLE) begin
        tick_cnt_reg <= '0;
      end else if (running_reg) begin
        tick_cnt_reg <= (tick_cnt_reg == TICK_MAX) ? '0 : tick_cnt_reg + 1'b1;
      end
    end
  end

  // Scan prescaler: free-running in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_reg <= '0;
      scan_en_reg  <= 1'b0;
    end else begin
      scan_en_reg  <= (scan_cnt_reg == SCAN_MAX);
      scan_cnt_reg <= (scan_cnt_reg == SCAN_MAX) ? '0 : scan_cnt_reg + 1'b1;
    end
  end

  assign state   = state_reg;
  assign running = running_reg;
  assign freeze  = freeze_reg;
  assign clr     = clr_reg;
  assign tick_en = tick_en_reg;
  assign scan_en = scan_en_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with TICK_DIV=4, SCAN_DIV=3: directed scenarios
// plus random button traffic, every cycle compared against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int TDIV = 4;
  localparam int SDIV = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_lap;
  logic       tick_en, clr, freeze, scan_en, running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TDIV), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_lap(btn_lap),
    .tick_en(tick_en), .clr(clr), .freeze(freeze), .scan_en(scan_en),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: transition tables indexed by state number 0..3
  // (0 idle, 1 run, 2 pause, 3 lap) and arithmetic on elapsed cycles.
  int on_start[4];
  int on_lap[4];
  int lap_clears[4];
  int m_state, m_acc, m_edges;
  bit m_prev_s, m_prev_l;
  bit e_tick, e_clr, e_scan;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_edges = 0;
    m_prev_s = 1'b1; m_prev_l = 1'b1;
    e_tick = 0; e_clr = 0; e_scan = 0;
  endtask

  // Apply buttons for one clock edge, advance the model, compare all outputs.
  task automatic cyc(input bit s, input bit l);
    bit se, le, was_running;
    btn_start = s;
    btn_lap   = l;
    @(posedge clk);
    se = s && !m_prev_s;
    le = l && !m_prev_l;
    m_prev_s = s;
    m_prev_l = l;
    was_running = (m_state == 1) || (m_state == 3);
    e_tick = 0;
    if (was_running) begin
      m_acc++;
      e_tick = (m_acc % TDIV) == 0;
    end
    e_clr = 0;
    if (se) m_state = on_start[m_state];
    else if (le) begin
      e_clr = lap_clears[m_state] != 0;
      m_state = on_lap[m_state];
    end
    if (m_state == 0) m_acc = 0;
    m_edges++;
    e_scan = (m_edges >= SDIV) && (m_edges % SDIV == 0);
    #1;
    chk("state", state, 2'(m_state));
    chk("running", {1'b0, running}, {1'b0, (m_state == 1 || m_state == 3)});
    chk("freeze", {1'b0, freeze}, {1'b0, (m_state == 3)});
    chk("clr", {1'b0, clr}, {1'b0, e_clr});
    chk("tick_en", {1'b0, tick_en}, {1'b0, e_tick});
    chk("scan_en", {1'b0, scan_en}, {1'b0, e_scan});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 2'b00);
    chk({tag, "_outs"}, {1'b0, tick_en | clr | freeze | scan_en | running}, 2'b00);
  endtask

  initial begin
    int hits, first, iter;
    on_start   = '{1, 2, 1, 2};
    on_lap     = '{0, 3, 0, 1};
    lap_clears = '{1, 0, 1, 0};

    // Reset state
    reset_n = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cyc(0, 0); cyc(0, 0);

    // Start from IDLE: ticks 4, 8, 12 cycles after the start edge
    cyc(1, 0);
    chk("start_state", state, 2'b01);
    hits = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0);
      if (tick_en) hits |= (1 << i);
    end
    chk("tick_times", 2'(hits == ((1 << 4) | (1 << 8) | (1 << 12))), 2'b01);
    $display("step start: tick mask %0h", hits);

    // Pause 2 cycles after a tick, wait 10, resume: next tick 2 cycles later
    cyc(0, 0);
    cyc(1, 0);
    chk("pause_state", state, 2'b10);
    repeat (10) cyc(0, 0);
    cyc(1, 0);
    first = -1;
    for (int i = 1; i <= 8 && first < 0; i++) begin
      cyc(0, 0);
      if (tick_en) first = i;
    end
    chk("resume_tick", 2'(first == 2), 2'b01);
    $display("step resume: first tick after %0d cycles", first);

    // Lap view holds display while ticks continue; second lap returns to RUN
    cyc(0, 1);
    chk("lap_state", state, 2'b11);
    chk("lap_freeze", {1'b0, freeze}, 2'b01);
    hits = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1);
      if (tick_en) hits++;
    end
    chk("lap_ticks", 2'(hits == 2), 2'b01);
    cyc(0, 0);
    cyc(0, 1);
    chk("unlap_state", state, 2'b01);
    chk("unlap_freeze", {1'b0, freeze}, 2'b00);
    $display("step lap: %0d ticks while frozen", hits);

    // PAUSE + lap -> IDLE with one clr, then first tick 4 cycles after start
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    chk("clear_state", state, 2'b00);
    chk("clear_pulse", {1'b0, clr}, 2'b01);
    cyc(0, 0);
    chk("clear_once", {1'b0, clr}, 2'b00);
    cyc(1, 0);
    first = -1;
    for (int i = 1; i <= 10 && first < 0; i++) begin
      cyc(0, 0);
      if (tick_en) first = i;
    end
    chk("restart_tick", 2'(first == 4), 2'b01);
    $display("step clear: first tick after restart at %0d", first);

    // Simultaneous start+lap while running: start wins, no clr
    cyc(1, 1);
    chk("simul_state", state, 2'b10);
    chk("simul_clr", {1'b0, clr}, 2'b00);
    $display("step simultaneous: state %0d", state);

    // Random button traffic
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
    end
    $display("step random: 400 cycles, errors so far %0d", errors);

    // Drive into LAP, then assert reset asynchronously
    iter = 0;
    while (m_state != 3 && iter < 10) begin
      cyc(0, 0);
      if (m_state == 1) cyc(0, 1);
      else if (m_state != 3) cyc(1, 0);
      iter++;
    end
    chk("reach_lap", state, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    $display("step async reset in lap: state %0d", state);

    // Hold start through reset: no edge, stay IDLE
    btn_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (6) cyc(1, 0);
    chk("held_start", state, 2'b00);
    cyc(0, 0);
    cyc(1, 0);
    chk("post_held_start", state, 2'b01);
    repeat (10) cyc(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
